// File: rtl/sprite_palette_pkg.sv
// ============================================================================
// Module   : sprite_palette_pkg
// Purpose  : Shared types and default constants for the sprite palette block:
//            controller state encoding, default parameter values, the packed
//            colour struct and the bank-select width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sprite_palette_pkg;

  localparam int DEFAULT_INDEX_W      = 4;
  localparam int DEFAULT_CH_W         = 4;
  localparam int DEFAULT_NUM_BANKS    = 2;
  localparam int DEFAULT_TRANSP_INDEX = 1;

  // Controller state: INIT sweeps the table to zero, RUN serves writes.
  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Colour entry at the default channel width, packed as {red, green, blue}.
  typedef struct packed {
    logic [DEFAULT_CH_W-1:0] red;
    logic [DEFAULT_CH_W-1:0] green;
    logic [DEFAULT_CH_W-1:0] blue;
  } rgb_t;

  // Bank-select width: a single bank still gets a 1-bit select port.
  function automatic int bank_width(input int num_banks);
    return (num_banks <= 2) ? 1 : $clog2(num_banks);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_palette_ram.sv
// ============================================================================
// Module   : sprite_palette_ram
// Purpose  : Banked colour storage, NUM_BANKS x 2**INDEX_W x 3*CH_W.
//            One synchronous write port (optionally broadcast to all banks)
//            and one combinational read port.
// Ports    : clk_i        - clock
//            we_i         - write enable
//            we_all_i     - write the same entry in every bank
//            wr_bank_i    - bank to write (ignored when we_all_i=1)
//            wr_index_i   - entry to write
//            wr_data_i    - {red, green, blue} to store
//            rd_bank_i    - bank to read; out-of-range banks read as zero
//            rd_index_i   - entry to read
//            rd_data_o    - combinational read data
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_palette_ram
  import sprite_palette_pkg::*;
#(
  parameter int INDEX_W   = DEFAULT_INDEX_W,
  parameter int CH_W      = DEFAULT_CH_W,
  parameter int NUM_BANKS = DEFAULT_NUM_BANKS,
  parameter int BANK_W    = bank_width(NUM_BANKS)
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic                we_all_i,
  input  logic [BANK_W-1:0]   wr_bank_i,
  input  logic [INDEX_W-1:0]  wr_index_i,
  input  logic [3*CH_W-1:0]   wr_data_i,
  input  logic [BANK_W-1:0]   rd_bank_i,
  input  logic [INDEX_W-1:0]  rd_index_i,
  output logic [3*CH_W-1:0]   rd_data_o
);

  localparam int ENTRIES = 2**INDEX_W;

  logic [3*CH_W-1:0] bank_rd [NUM_BANKS];

  // Each bank owns its own array so no storage element has two writers.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [3*CH_W-1:0] mem_q [ENTRIES];

    always_ff @(posedge clk_i) begin
      if (we_i && (we_all_i || (32'(wr_bank_i) == b))) begin
        mem_q[wr_index_i] <= wr_data_i;
      end
    end

    assign bank_rd[b] = mem_q[rd_index_i];
  end

  assign rd_data_o = (32'(rd_bank_i) < NUM_BANKS) ? bank_rd[rd_bank_i] : '0;

endmodule

`default_nettype wire

// File: rtl/sprite_palette.sv
// ============================================================================
// Module   : sprite_palette
// Purpose  : Banked sprite colour palette with a fixed 2-cycle lookup pipe.
//            After reset the table is zero-filled by an INIT sweep of
//            2**INDEX_W cycles; writes are accepted only in RUN.
// Ports    : clk_i          - clock, rising edge
//            rst_ni         - asynchronous active-low reset
//            rd_valid_i     - lookup strobe
//            rd_bank_i      - lookup bank
//            rd_index_i     - lookup index
//            wr_en_i        - write request
//            wr_bank_i      - write bank
//            wr_index_i     - write index
//            wr_rgb_i       - {red, green, blue} to store
//            wr_ready_o     - writes accepted this cycle
//            out_valid_o    - lookup result valid
//            red_o/green_o/blue_o - looked-up colour
//            out_transp_o   - looked-up index equals TRANSP_INDEX
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_palette
  import sprite_palette_pkg::*;
#(
  parameter int INDEX_W      = DEFAULT_INDEX_W,
  parameter int CH_W         = DEFAULT_CH_W,
  parameter int NUM_BANKS    = DEFAULT_NUM_BANKS,
  parameter int TRANSP_INDEX = DEFAULT_TRANSP_INDEX,
  parameter int BANK_W       = bank_width(NUM_BANKS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                rd_valid_i,
  input  logic [BANK_W-1:0]   rd_bank_i,
  input  logic [INDEX_W-1:0]  rd_index_i,
  input  logic                wr_en_i,
  input  logic [BANK_W-1:0]   wr_bank_i,
  input  logic [INDEX_W-1:0]  wr_index_i,
  input  logic [3*CH_W-1:0]   wr_rgb_i,
  output logic                wr_ready_o,
  output logic                out_valid_o,
  output logic [CH_W-1:0]     red_o,
  output logic [CH_W-1:0]     green_o,
  output logic [CH_W-1:0]     blue_o,
  output logic                out_transp_o
);

  // ---------------------------------------------------------------- control
  state_e             state_q, state_d;
  logic [INDEX_W-1:0] cnt_q, cnt_d;

  logic               ram_we;
  logic               ram_we_all;
  logic [BANK_W-1:0]  ram_wr_bank;
  logic [INDEX_W-1:0] ram_wr_index;
  logic [3*CH_W-1:0]  ram_wr_data;
  logic               wr_bank_ok;

  assign wr_bank_ok = (32'(wr_bank_i) < NUM_BANKS);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_ready_o   = 1'b0;
    ram_we       = 1'b0;
    ram_we_all   = 1'b0;
    ram_wr_bank  = wr_bank_i;
    ram_wr_index = wr_index_i;
    ram_wr_data  = wr_rgb_i;
    case (state_q)
      INIT: begin
        // Zero one entry in every bank per cycle; user writes are dropped.
        ram_we       = 1'b1;
        ram_we_all   = 1'b1;
        ram_wr_index = cnt_q;
        ram_wr_data  = '0;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == {INDEX_W{1'b1}}) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        wr_ready_o = 1'b1;
        ram_we     = wr_en_i && wr_bank_ok;
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------- storage
  logic [BANK_W-1:0]  s1_bank_q;
  logic [INDEX_W-1:0] s1_index_q;
  logic               s1_valid_q;
  logic [3*CH_W-1:0]  ram_rd_data;

  sprite_palette_ram #(
    .INDEX_W   (INDEX_W),
    .CH_W      (CH_W),
    .NUM_BANKS (NUM_BANKS),
    .BANK_W    (BANK_W)
  ) u_ram (
    .clk_i      (clk_i),
    .we_i       (ram_we),
    .we_all_i   (ram_we_all),
    .wr_bank_i  (ram_wr_bank),
    .wr_index_i (ram_wr_index),
    .wr_data_i  (ram_wr_data),
    .rd_bank_i  (s1_bank_q),
    .rd_index_i (s1_index_q),
    .rd_data_o  (ram_rd_data)
  );

  // --------------------------------------------------------------- pipeline
  // The table is read from the stage-1 registers, i.e. one edge after the
  // request, so a write accepted in the request cycle is already visible.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_bank_q  <= '0;
      s1_index_q <= '0;
    end else begin
      s1_valid_q <= rd_valid_i;
      s1_bank_q  <= rd_bank_i;
      s1_index_q <= rd_index_i;
    end
  end

  logic              out_valid_q;
  logic [3*CH_W-1:0] rgb_q;
  logic              transp_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      rgb_q       <= '0;
      transp_q    <= 1'b0;
    end else begin
      out_valid_q <= s1_valid_q;
      // Result registers hold their last value while no lookup completes.
      if (s1_valid_q) begin
        rgb_q    <= ram_rd_data;
        transp_q <= (s1_index_q == INDEX_W'(TRANSP_INDEX));
      end
    end
  end

  assign out_valid_o  = out_valid_q;
  assign red_o        = rgb_q[3*CH_W-1:2*CH_W];
  assign green_o      = rgb_q[2*CH_W-1:CH_W];
  assign blue_o       = rgb_q[CH_W-1:0];
  assign out_transp_o = transp_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_palette.sv
// ============================================================================
// Module   : tb_sprite_palette
// Purpose  : Directed self-checking bench for sprite_palette. A reference
//            table model and a queue of expected lookup results are updated
//            as stimulus is driven and compared as results emerge.
//            Three banks are instantiated so that bank select 3 is a real
//            out-of-range value on a 2-bit bank port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_palette;
  import sprite_palette_pkg::*;

  localparam int NB = 3;

  logic        clk;
  logic        rst_n;
  logic        rd_valid;
  logic [1:0]  rd_bank;
  logic [3:0]  rd_index;
  logic        wr_en;
  logic [1:0]  wr_bank;
  logic [3:0]  wr_index;
  logic [11:0] wr_rgb;
  logic        wr_ready;
  logic        out_valid;
  logic [3:0]  red, green, blue;
  logic        out_transp;

  sprite_palette #(
    .INDEX_W      (4),
    .CH_W         (4),
    .NUM_BANKS    (NB),
    .TRANSP_INDEX (1)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rd_valid_i   (rd_valid),
    .rd_bank_i    (rd_bank),
    .rd_index_i   (rd_index),
    .wr_en_i      (wr_en),
    .wr_bank_i    (wr_bank),
    .wr_index_i   (wr_index),
    .wr_rgb_i     (wr_rgb),
    .wr_ready_o   (wr_ready),
    .out_valid_o  (out_valid),
    .red_o        (red),
    .green_o      (green),
    .blue_o       (blue),
    .out_transp_o (out_transp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   due;
    rgb_t rgb;
    logic transp;
  } exp_t;

  exp_t q[$];
  rgb_t model [4][16];
  rgb_t last_rgb;
  logic last_transp;
  int   cyc;
  int   rel_cyc;
  logic in_reset;
  int   total;
  int   bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic ready_exp();
    return !in_reset && (cyc >= rel_cyc + 16);
  endfunction

  task automatic clear_model();
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 16; i++)
        model[b][i] = '0;
  endtask

  // Advance one clock and check everything visible in the new cycle.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    chk("wr_ready", 32'(wr_ready), 32'(ready_exp()));
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("rgb", 32'({red, green, blue}), 32'(e.rgb));
      chk("transp", 32'(out_transp), 32'(e.transp));
      last_rgb    = e.rgb;
      last_transp = e.transp;
    end else begin
      chk("out_valid_idle", 32'(out_valid), 32'd0);
      chk("rgb_hold", 32'({red, green, blue}), 32'(last_rgb));
      chk("transp_hold", 32'(out_transp), 32'(last_transp));
    end
  endtask

  // Drive one cycle of stimulus; the model applies an accepted write before
  // evaluating a same-cycle lookup, so the lookup sees the new value.
  task automatic drive(input logic rv, input logic [1:0] rb, input logic [3:0] ri,
                       input logic we, input logic [1:0] wb, input logic [3:0] wi,
                       input logic [11:0] rgb);
    exp_t e;
    rd_valid = rv;
    rd_bank  = rb;
    rd_index = ri;
    wr_en    = we;
    wr_bank  = wb;
    wr_index = wi;
    wr_rgb   = rgb;
    if (we && ready_exp() && (32'(wb) < NB)) model[wb][wi] = rgb;
    if (rv) begin
      e.due    = cyc + 2;
      e.rgb    = (32'(rb) < NB) ? model[rb][ri] : rgb_t'(12'h000);
      e.transp = (ri == 4'd1);
      q.push_back(e);
    end
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0, 12'h000);
  endtask

  task automatic lookup(input logic [1:0] rb, input logic [3:0] ri);
    drive(1'b1, rb, ri, 1'b0, 2'd0, 4'd0, 12'h000);
  endtask

  task automatic write(input logic [1:0] wb, input logic [3:0] wi, input logic [11:0] rgb);
    drive(1'b0, 2'd0, 4'd0, 1'b1, wb, wi, rgb);
  endtask

  task automatic sweep();
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 16; i++)
        lookup(2'(b), 4'(i));
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; rel_cyc = 0;
    in_reset = 1'b1; last_rgb = '0; last_transp = 1'b0;
    clear_model();
    rst_n = 1'b0;
    rd_valid = 1'b0; rd_bank = '0; rd_index = '0;
    wr_en = 1'b0; wr_bank = '0; wr_index = '0; wr_rgb = '0;

    // Reset state.
    repeat (3) idle();

    // Release; cycle 1 of INIT is the current cycle.
    rst_n = 1'b1;
    in_reset = 1'b0;
    rel_cyc = cyc;
    chk("ready_c1", 32'(wr_ready), 32'(ready_exp()));

    // INIT: writes must be dropped, lookups return zero with out_valid.
    for (int k = 0; k < 16; k++)
      drive(1'b1, 2'(k % 4), 4'(k), 1'b1, 2'(k % 3), 4'((k + 5) % 16), 12'h5A5);

    // RUN: two banks at the same index, then back-to-back lookups.
    write(2'd0, 4'd5, 12'hF76);
    write(2'd1, 4'd5, 12'h922);
    write(2'd3, 4'd5, 12'hFFF);
    lookup(2'd0, 4'd5);
    lookup(2'd1, 4'd5);
    lookup(2'd2, 4'd5);

    // Read-during-write: old value one cycle earlier, new value same cycle.
    lookup(2'd0, 4'd3);
    drive(1'b1, 2'd0, 4'd3, 1'b1, 2'd0, 4'd3, 12'hABC);
    lookup(2'd0, 4'd3);

    // Transparent index.
    write(2'd0, 4'd1, 12'hF0F);
    lookup(2'd0, 4'd1);
    lookup(2'd0, 4'd2);
    lookup(2'd3, 4'd1);
    idle();
    idle();
    idle();

    // Full table against the model, including the out-of-range bank.
    write(2'd2, 4'd15, 12'h3C7);
    sweep();
    repeat (3) idle();

    // Mid-pipeline reset: first result lands, the second must vanish.
    lookup(2'd0, 4'd5);
    lookup(2'd1, 4'd5);
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_rgb", 32'({red, green, blue}), 32'd0);
    chk("rst_transp", 32'(out_transp), 32'd0);
    chk("rst_ready", 32'(wr_ready), 32'd0);
    q.delete();
    in_reset = 1'b1;
    clear_model();
    last_rgb = '0;
    last_transp = 1'b0;
    idle();
    rst_n = 1'b1;
    in_reset = 1'b0;
    rel_cyc = cyc;

    // Second INIT with write attempts, then verify the table is re-zeroed.
    for (int k = 0; k < 16; k++)
      write(2'd0, 4'd5, 12'h777);
    lookup(2'd0, 4'd5);
    sweep();

    for (int g = 0; g < 20 && q.size() > 0; g++) idle();
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sprite_palette.md
SPRITE_PALETTE -- requirements
Module: sprite_palette

Interface
REQ-001 Parameter INDEX_W, default 4, palette index width; entries per bank = 2**INDEX_W.
REQ-002 Parameter CH_W, default 4, width of each colour channel.
REQ-003 Parameter NUM_BANKS, default 2, number of independent palettes; BANK_W = max(1, clog2(NUM_BANKS)).
REQ-004 Parameter TRANSP_INDEX, default 1, index flagged as transparent.
REQ-005 Clk  input  1  sole clock; all state updates on rising edge.
REQ-006 Reset_n  input  1  asynchronous active-low reset.
REQ-007 rd_valid  input  1  lookup request strobe.
REQ-008 rd_bank  input  BANK_W  palette bank for lookup.
REQ-009 rd_index  input  INDEX_W  palette index for lookup.
REQ-010 wr_en  input  1  write request.
REQ-011 wr_bank  input  BANK_W  bank to write.
REQ-012 wr_index  input  INDEX_W  entry to write.
REQ-013 wr_rgb  input  3*CH_W  {red, green, blue} to store.
REQ-014 wr_ready  output  1  writes accepted this cycle.
REQ-015 out_valid  output  1  lookup result valid.
REQ-016 red, green, blue  output  CH_W each  looked-up colour.
REQ-017 out_transp  output  1  looked-up index equals TRANSP_INDEX.

Function
REQ-018 FSM states INIT and RUN; reset enters INIT.
REQ-019 INIT: entry counter sweeps 0..2**INDEX_W-1, writing all-zero colour to that entry in every bank each cycle; wr_ready=0.
REQ-020 INIT->RUN on the cycle after the counter writes the last entry; exactly 2**INDEX_W INIT cycles after reset release.
REQ-021 RUN: wr_ready=1; write accepted when wr_en=1, updating entry (wr_bank, wr_index) at that edge.
REQ-022 wr_en during INIT is ignored (dropped, not queued).
REQ-023 wr_bank >= NUM_BANKS: write dropped; rd_bank >= NUM_BANKS: lookup returns all-zero colour, out_transp still computed.
REQ-024 Lookup latency fixed 2 cycles: request at cycle N yields out_valid=1 with data at cycle N+2; one lookup per cycle, no backpressure.
REQ-025 Stage 1 registers rd_valid, rd_bank, rd_index; stage 2 registers table output, out_transp, out_valid.
REQ-026 Read-during-write: write accepted at end of cycle N is visible to a lookup requested in cycle N (same cycle) or later; lookup requested in cycle N-1 returns old value.
REQ-027 Lookups during INIT propagate with out_valid=1 and colour all-zero.
REQ-028 out_transp depends on index only, never on bank or stored colour; colour still output when transparent.
REQ-029 When out_valid=0, red/green/blue/out_transp hold their previous values.

Reset
REQ-030 Reset_n low asynchronously forces: state INIT, counter 0, both pipeline stages invalid, out_valid=0, red=green=blue=0, out_transp=0, wr_ready=0.
REQ-031 Reset asserted mid-INIT or mid-RUN aborts in-flight lookups (no out_valid for them) and restarts full INIT sweep after release.
REQ-032 Table storage needs no reset; INIT sweep defines contents.

Structure
REQ-033 Package sprite_palette_pkg holds state enum (INIT, RUN), default parameter constants, and rgb struct type.
REQ-034 Sub-module sprite_palette_ram: NUM_BANKS x 2**INDEX_W x 3*CH_W storage, one sync write port, one combinational read port; FSM, INIT counter, write arbitration, pipeline in top.

Verification
REQ-035 Reset release, no writes -> wr_ready=0 for 16 cycles, 1 from cycle 17; lookup any bank/index -> rgb 000.
REQ-036 RUN: write bank0 idx5 = F,7,6 and bank1 idx5 = 9,2,2; lookups bank0/5 then bank1/5 back-to-back -> outputs F76 then 922 at request+2, out_valid each cycle.
REQ-037 Same cycle write bank0 idx3 = ABC and lookup bank0 idx3 -> ABC at N+2; lookup at N-1 -> old value 000.
REQ-038 Lookup idx1 (TRANSP_INDEX) after writing F0F -> rgb F0F, out_transp=1; idx2 -> out_transp=0.
REQ-039 Issue lookups, assert Reset_n low for 1 cycle mid-pipeline -> out_valid=0 immediately, no stale results, table re-zeroed (prior F76 reads 000).
REQ-040 wr_en during INIT and wr_bank=3 with NUM_BANKS=2 -> no entry changes, verified by full-table sweep.
